// File: rtl/datamemory_arb_pkg.sv
// Shared types for the datamemory arbiter: FSM state encoding and port indices.
package datamemory_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam int unsigned PORT_CPU = 0;
  localparam int unsigned PORT_DMA = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way one-hot grant with a last-grant pointer (round-robin on ties).
// DATAMEM_ARB_FIXED_PRIO_EN selects fixed priority (CPU port wins) with no pointer.
module rr_arbiter2
  import datamemory_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef DATAMEM_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, accept};

  always_comb begin
    grant = '0;
    if (req[PORT_CPU])      grant[PORT_CPU] = 1'b1;
    else if (req[PORT_DMA]) grant[PORT_DMA] = 1'b1;
  end
`else
  // Set when the DMA port won the most recent accepted request.
  logic last_dma;

  always_comb begin
    grant = '0;
    if (req[PORT_CPU] && req[PORT_DMA]) begin
      if (last_dma) grant[PORT_CPU] = 1'b1;
      else          grant[PORT_DMA] = 1'b1;
    end else begin
      grant = req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_dma <= 1'b1;
    else if (accept) last_dma <= grant[PORT_DMA];
  end
`endif

endmodule

// File: rtl/datamemory_arbiter.sv
// Two-port arbiter/sequencer owning the single-port datamemory control pins.
// DATAMEM_ARB_FIXED_PRIO_EN: fixed priority instead of round-robin arbitration.
module datamemory_arbiter
  import datamemory_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);

  state_t                state;
  logic [1:0]            grant;
  logic                  accept;
  logic                  cmd_port;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign req_ready   = (state == IDLE) ? grant : '0;
  assign accept      = |(req_valid & req_ready);
  assign mem_address = cmd_addr;
  assign mem_dataIn  = cmd_wdata;
  // Decoded from state so an async reset drops the write strobe immediately.
  assign mem_we      = (state == ISSUE) && cmd_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (grant[PORT_DMA]) begin
              cmd_port  <= 1'b1;
              cmd_we    <= req_we[PORT_DMA];
              cmd_addr  <= req_addr1;
              cmd_wdata <= req_wdata1;
            end else begin
              cmd_port  <= 1'b0;
              cmd_we    <= req_we[PORT_CPU];
              cmd_addr  <= req_addr0;
              cmd_wdata <= req_wdata0;
            end
            state <= ISSUE;
          end
        end
        ISSUE: state <= DATA;
        DATA: begin
          if (!cmd_we) rsp_rdata <= mem_dataOut;
          rsp_valid[cmd_port] <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamemory_arbiter.sv
// Self-checking bench for datamemory_arbiter with a behavioural memory and a
// transaction-level reference model (serialised 3-cycle accesses, RR/fixed ties).
module tb_datamemory_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [AW-1:0] req_addr0, req_addr1, mem_address;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, mem_dataIn, mem_dataOut;
  logic          mem_we;
  logic          preload;
  logic [DW-1:0] mem [0:1023];

  always #5 clk = ~clk;

  datamemory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_we(mem_we), .mem_dataOut(mem_dataOut)
  );

  function automatic logic [DW-1:0] init_word(int i);
    case (i)
      0: return 32'd1000;
      1: return 32'd5000;
      2: return 32'd2000;
      3: return 32'd3000;
      default: return 32'd100 + 32'(i);
    endcase
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_we) mem[mem_address] <= mem_dataIn;
      mem_dataOut <= mem[mem_address];
    end
  end

  int checks = 0, errors = 0;
  int m_busy, m_last, m_port, rsp_cnt = 0;
  logic m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd, exp_rdata, last_rd;
  logic [1:0] exp_rsp, last_rv;
  logic [DW-1:0] ref_mem [0:15];
  logic [1:0] pv, pw;
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];
  logic [1:0] grant_log [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] pick(logic [1:0] v);
    if (v != 2'b11) return v;
`ifdef DATAMEM_ARB_FIXED_PRIO_EN
    return 2'b01;
`else
    return (m_last == 1) ? 2'b01 : 2'b10;
`endif
  endfunction

  task automatic drive();
    req_valid = pv; req_we = pw;
    req_addr0 = pa[0]; req_addr1 = pa[1];
    req_wdata0 = pd[0]; req_wdata1 = pd[1];
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic cycle();
    logic [1:0] er;
    drive();
    #1;
    er = (m_busy == 0) ? pick(pv) : 2'b00;
    check("req_ready", 64'(req_ready), 64'(er));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
    check("mem_we", 64'(mem_we), 64'((m_busy == 2) && m_we));
    if (req_ready != 2'b00) grant_log.push_back(req_ready);
    if (exp_rsp != 2'b00) begin last_rd = rsp_rdata; last_rv = rsp_valid; rsp_cnt++; end
    @(posedge clk);
    exp_rsp = 2'b00;
    if (m_busy == 0) begin
      if (er != 2'b00) begin
        m_port = er[1] ? 1 : 0;
        m_we = pw[m_port]; m_addr = pa[m_port]; m_data = pd[m_port];
        m_last = m_port; pv[m_port] = 1'b0; m_busy = 2;
      end
    end else if (m_busy == 2) begin
      if (m_we) ref_mem[m_addr[3:0]] = m_data;
      else m_rd = ref_mem[m_addr[3:0]];
      m_busy = 1;
    end else begin
      m_busy = 0;
      exp_rsp = (m_port == 1) ? 2'b10 : 2'b01;
      if (!m_we) exp_rdata = m_rd;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    pv = 2'b00; drive();
    rst = 1'b1;
    #1;
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    m_busy = 0; m_last = 1; exp_rsp = 2'b00; exp_rdata = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int c0, n;
    pv[p] = 1'b1; pw[p] = we; pa[p] = a; pd[p] = d;
    c0 = rsp_cnt; n = 0;
    while (rsp_cnt == c0 && n < 20) begin cycle(); n++; end
    check("req_done", 64'(rsp_cnt - c0), 64'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; preload = 1'b1;
    pv = 2'b00; pw = 2'b00; pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    drive();
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    m_busy = 0; m_last = 1; exp_rsp = 2'b00; exp_rdata = '0; last_rd = '0; last_rv = 2'b00;
    @(negedge clk);
    check("rst_mem_address", 64'(mem_address), 64'd0);
    check("rst_mem_dataIn", 64'(mem_dataIn), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_mem_we0", 64'(mem_we), 64'd0);
    check("rst_rsp_valid0", 64'(rsp_valid), 64'd0);
    check("rst_req_ready0", 64'(req_ready), 64'd0);
    preload = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    do_req(0, 1'b0, 10'd1, '0);
    check("rd1_port", 64'(last_rv), 64'd1);
    check("rd1_data", 64'(last_rd), 64'd5000);

    do_req(1, 1'b1, 10'd2, 32'd1234);
    check("wr2_ack", 64'(last_rv), 64'd2);
    do_req(0, 1'b0, 10'd2, '0);
    check("raw2_port", 64'(last_rv), 64'd1);
    check("raw2_data", 64'(last_rd), 64'd1234);

    // Port 0 arrives while port 1 is in flight.
    pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 10'd3;
    n = 0;
    while (pv[1] && n < 10) begin cycle(); n++; end
    pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 10'd0;
    grant_log.delete();
    for (int i = 0; i < 6; i++) cycle();
    check("hold_grant_cnt", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() > 0) check("hold_grant", 64'(grant_log[0]), 64'd1);
    check("hold_data", 64'(last_rd), 64'd1000);

    // Both ports requesting continuously.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 24; i++) begin
      if (!pv[0]) begin pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 10'd0; end
      if (!pv[1]) begin pv[1] = 1'b1; pw[1] = 1'b0; pa[1] = 10'd3; end
      cycle();
    end
    pv = 2'b00;
    for (int i = 0; i < 4; i++) cycle();
    check("alt_count", 64'(grant_log.size()), 64'd8);
    for (int k = 0; k < grant_log.size(); k++) begin
`ifdef DATAMEM_ARB_FIXED_PRIO_EN
      check("alt_grant", 64'(grant_log[k]), 64'd1);
`else
      check("alt_grant", 64'(grant_log[k]), (k % 2 == 0) ? 64'd1 : 64'd2);
`endif
    end

    // Reset while a port 0 write is in ISSUE.
    pv[0] = 1'b1; pw[0] = 1'b1; pa[0] = 10'd0; pd[0] = 32'd777;
    n = 0;
    while (pv[0] && n < 10) begin cycle(); n++; end
    drive();
    #1;
    check("issue_we", 64'(mem_we), 64'd1);
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    do_req(0, 1'b0, 10'd0, '0);
    check("abort_data", 64'(last_rd), 64'd1000);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && ($urandom_range(1, 0) == 1)) begin
          pv[p] = 1'b1;
          pw[p] = ($urandom_range(2, 0) == 0);
          pa[p] = AW'($urandom_range(15, 0));
          pd[p] = $urandom;
        end
      end
      cycle();
    end
    pv = 2'b00;
    for (int i = 0; i < 4; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/datamemory_arbiter.md
# datamemory_arbiter

Two-port arbiter and sequencer in front of the single-port `datamemory` block. Port 0 (CPU load/store) and port 1 (DMA/debug) issue word read/write requests over valid/ready. The block grants one requester at a time, drives the memory's address/dataIn/we for exactly one write cycle, and returns a registered response. It owns the memory's control pins outright; nothing else drives them.

## Interface
- DATA_WIDTH, 32, word width of memory and request/response data
- ADDR_WIDTH, 10, word address width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port accept; at most one bit high
- req_we  in  2  per-port 1 = write, 0 = read
- req_addr0 / req_addr1  in  ADDR_WIDTH  word address, ports 0/1
- req_wdata0 / req_wdata1  in  DATA_WIDTH  write data, ports 0/1
- rsp_valid  out  2  one-cycle response pulse to the granted port
- rsp_rdata  out  DATA_WIDTH  read data, shared, qualified by rsp_valid
- mem_address  out  ADDR_WIDTH  to datamemory address
- mem_dataIn  out  DATA_WIDTH  to datamemory dataIn
- mem_we  out  1  to datamemory we
- mem_dataOut  in  DATA_WIDTH  from datamemory dataOut (1-cycle synchronous read)

## Operation
- FSM states: IDLE, ISSUE, DATA.
- IDLE: req_ready is combinational and equals the one-hot grant over req_valid. On an edge with valid&ready, latch addr/we/wdata/port into command registers and go to ISSUE. With no valid, stay in IDLE.
- ISSUE: mem_we = latched we. The memory performs the access on this edge. Go to DATA.
- DATA: mem_dataOut holds the read word. On the edge: rsp_rdata <= mem_dataOut (reads only; writes leave rsp_rdata unchanged), rsp_valid[port] <= 1, go to IDLE.
- rsp_valid is a single-cycle pulse. Writes also get a pulse, as an ack.
- mem_address and mem_dataIn are always driven from the command registers. mem_we is 0 in every state except ISSUE.
- Arbitration is round-robin with a last-grant pointer. On a tie, the port that was not granted last wins. A lone requester always wins. The pointer updates only on accept.
- Requesters hold valid and payload stable until ready. Valid must not depend on ready.
- A request that arrives in ISSUE or DATA waits; req_ready stays 0 there.

## Timing
- Reset values: state IDLE, req_ready 0, rsp_valid 0, rsp_rdata 0, mem_we 0, mem_address 0, mem_dataIn 0, last-grant pointer = port 1 (so port 0 wins the first tie).
- Latency: accept at edge E0, memory access at E1, rsp_valid high in the cycle after E2.
- The earliest next accept is at E3. Peak throughput is one access per 3 cycles.
- Back-to-back requests from both ports alternate: 0,1,0,1…
- Reset mid-operation: mem_we drops immediately, because it is decoded from state. The in-flight access is abandoned and no response is issued. A write that is not yet past its ISSUE edge is not performed.
- Read-after-write from either port returns the new data, since accesses are serialised.

## Configuration
- DATAMEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins ties, and the pointer logic is removed.
- Not defined (default): round-robin as above.

## Structure
- Package datamemory_arb_pkg holds the FSM state typedef (IDLE/ISSUE/DATA) and port index constants (PORT_CPU = 0, PORT_DMA = 1).
- One sub-module: rr_arbiter2. It is a 2-way grant with a last-grant pointer and contains the macro-selected fixed-priority variant.
- The FSM, command registers and response register live in the top module.

## Test plan
- Bench memory is preloaded with mem[0]=1000, mem[1]=5000, mem[2]=2000, mem[3]=3000.
- Port 0 reads addr 1 → rsp_valid = 01 two cycles after accept, rsp_rdata = 5000.
- Port 1 writes 1234 to addr 2, then port 0 reads addr 2 → ack on rsp_valid = 10, then rsp_rdata = 1234 on rsp_valid = 01.
- Both ports valid continuously, reading addr 0/3 → grants alternate 0,1,0,1. Data 1000/3000 arrives on matching rsp_valid bits, one access per 3 cycles. With DATAMEM_ARB_FIXED_PRIO_EN, port 0 starves port 1.
- Port 0 holds valid while the FSM is in ISSUE/DATA for port 1 → req_ready stays 00 until IDLE. Payload is accepted unchanged.
- rst asserted during ISSUE of a port 0 write of 777 to addr 0 → mem_we falls immediately, no rsp_valid. A later read of addr 0 returns 1000.
- Idle after reset → all outputs 0, mem_we never asserted.
